// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: screen geometry, colour indices, write-queue
// state encoding and the queued write record.
package fb_pkg;

    localparam int FB_WIDTH    = 640;
    localparam int FB_HEIGHT   = 480;
    localparam int FB_PIXELS   = 307200;
    localparam int FB_ADDR_W   = 19;
    localparam int FB_COLOUR_W = 3;

    localparam logic [FB_COLOUR_W-1:0] COLOUR_BLACK   = 3'd0;
    localparam logic [FB_COLOUR_W-1:0] COLOUR_BLUE    = 3'd1;
    localparam logic [FB_COLOUR_W-1:0] COLOUR_GREEN   = 3'd2;
    localparam logic [FB_COLOUR_W-1:0] COLOUR_CYAN    = 3'd3;
    localparam logic [FB_COLOUR_W-1:0] COLOUR_RED     = 3'd4;
    localparam logic [FB_COLOUR_W-1:0] COLOUR_MAGENTA = 3'd5;
    localparam logic [FB_COLOUR_W-1:0] COLOUR_YELLOW  = 3'd6;
    localparam logic [FB_COLOUR_W-1:0] COLOUR_WHITE   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CLEAR = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0]   addr;
        logic [FB_COLOUR_W-1:0] colour;
    } fb_wr_t;

    function automatic logic addr_in_range(input logic [FB_ADDR_W-1:0] addr,
                                           input int unsigned          pixels);
        return (32'(addr) < pixels);
    endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO with occupancy counter; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module fb_sync_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next-state; count tracks accepted push/pop events.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fb_write_queue.sv
// Buffers pixel writes ahead of the shared VGA index RAM port and provides a
// whole-screen clear engine that runs after all earlier writes have drained.
module fb_write_queue
    import fb_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  PIXELS = FB_PIXELS,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [FB_ADDR_W-1:0]   in_waddr,
    input  logic [FB_COLOUR_W-1:0] in_wdata,
    input  logic                   in_wenable,
    input  logic                   clear_start,
    input  logic [FB_COLOUR_W-1:0] clear_colour,
    input  logic                   ram_grant,
    output logic [FB_ADDR_W-1:0]   ram_waddr,
    output logic [FB_COLOUR_W-1:0] ram_wdata,
    output logic                   ram_wenable,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   busy,
    output logic                   clear_done,
    output logic                   overflow
);

    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(PIXELS - 1);

    fb_state_e              state_q, state_d;
    logic [FB_ADDR_W-1:0]   counter_q, counter_d;
    logic [FB_COLOUR_W-1:0] colour_q, colour_d;
    logic [FB_ADDR_W-1:0]   waddr_q, waddr_d;
    logic [FB_COLOUR_W-1:0] wdata_q, wdata_d;
    logic                   wenable_q, wenable_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;

    logic                   push_valid_s;
    logic                   pop_s;
    logic                   clear_wr_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    fb_wr_t                 push_entry_s;
    fb_wr_t                 head_entry_s;

    assign push_valid_s = in_wenable && addr_in_range(in_waddr, PIXELS);
    assign pop_s        = ram_grant && !fifo_empty_s &&
                          ((state_q == ST_IDLE) || (state_q == ST_FLUSH));
    assign clear_wr_s   = ram_grant && (state_q == ST_CLEAR);
    assign push_entry_s = '{addr: in_waddr, colour: in_wdata};

    fb_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fb_wr_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_valid_s),
        .pop_i   (pop_s),
        .wdata_i (push_entry_s),
        .rdata_o (head_entry_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count)
    );

    // FSM next-state, clear counter and RAM port next values.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        colour_d   = colour_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wenable_d  = 1'b0;
        done_d     = 1'b0;
        overflow_d = overflow_q | (push_valid_s && fifo_full_s && !pop_s);

        if (pop_s) begin
            waddr_d   = head_entry_s.addr;
            wdata_d   = head_entry_s.colour;
            wenable_d = 1'b1;
        end else if (clear_wr_s) begin
            waddr_d   = counter_q;
            wdata_d   = colour_q;
            wenable_d = 1'b1;
        end else begin
            wenable_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_FLUSH;
                    colour_d  = clear_colour;
                    counter_d = {FB_ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty_s) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_CLEAR: begin
                if (clear_wr_s && (counter_q == LAST_ADDR)) begin
                    state_d   = ST_IDLE;
                    counter_d = {FB_ADDR_W{1'b0}};
                    done_d    = 1'b1;
                end else if (clear_wr_s) begin
                    counter_d = counter_q + FB_ADDR_W'(1);
                end else begin
                    counter_d = counter_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any drain or clear in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            counter_q  <= {FB_ADDR_W{1'b0}};
            colour_q   <= {FB_COLOUR_W{1'b0}};
            waddr_q    <= {FB_ADDR_W{1'b0}};
            wdata_q    <= {FB_COLOUR_W{1'b0}};
            wenable_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            colour_q   <= colour_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wenable_q  <= wenable_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign ram_waddr   = waddr_q;
    assign ram_wdata   = wdata_q;
    assign ram_wenable = wenable_q;
    assign clear_done  = done_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule
